// File: rtl/snake_move_control_pkg.sv
// Shared direction encodings and helpers for the snake move-control path and the length DPU.
// The encodings are pure combinational definitions; the period helper never underflows.
package snake_move_control_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam int unsigned BASE_PERIOD_DEF = 25_000_000;
  localparam int unsigned STEP_DEF        = 500_000;
  localparam int unsigned MIN_PERIOD_DEF  = 5_000_000;
  localparam int unsigned QDEPTH_DEF      = 2;
  localparam int unsigned MIN_LENGTH      = 3;

  // Same axis lives in bit 1, sense in bit 0.
  function automatic logic is_reversal(input dir_e a, input dir_e b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  // Reduction is compared against the headroom before any subtraction.
  function automatic logic [31:0] move_period(input logic [7:0]  len,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] min_p);
    logic [31:0] segs;
    logic [31:0] red;
    segs = (32'(len) > MIN_LENGTH) ? (32'(len) - MIN_LENGTH) : 32'd0;
    red  = segs * step;
    if (base <= min_p || red >= (base - min_p)) begin
      return min_p;
    end
    return base - red;
  endfunction

endpackage

// File: rtl/snake_move_control_if.sv
// Button/length inputs and direction/tick outputs between the game FSM side and snake_move_control.
// Plain wires, no timing of its own; all strobes are single-cycle and carry no backpressure.
interface snake_move_control_if;
  logic       q_Run;
  logic       BtnU;
  logic       BtnD;
  logic       BtnL;
  logic       BtnR;
  logic [7:0] Length;
  logic [1:0] In_Dirn;
  logic       SCEN;
  logic       Speed_Clk;

  modport master (
    output q_Run, BtnU, BtnD, BtnL, BtnR, Length,
    input  In_Dirn, SCEN, Speed_Clk
  );

  modport slave (
    input  q_Run, BtnU, BtnD, BtnL, BtnR, Length,
    output In_Dirn, SCEN, Speed_Clk
  );
endinterface

// File: rtl/snake_dir_fifo.sv
// Small synchronous FIFO of pending turns; entries are readable the cycle after the push.
// Pushes while full and pops while empty are ignored; flush empties it in one cycle.
module snake_dir_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] last,
  output logic         full,
  output logic         empty
);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   last_idx;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign full     = (cnt_q == CNTW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign last_idx = (wr_q == '0) ? LAST_IDX : wr_q - PW'(1);
  assign head     = mem_q[rd_q];
  assign last     = mem_q[last_idx];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wrap_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = wrap_inc(rd_q);
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + CNTW'(1);
      end else if (!do_push && do_pop) begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_move_control.sv
// Button decode, turn queue and move-tick generator: a press is committed one cycle later at the
// earliest, at most one turn per move; no backpressure, excess or illegal presses are dropped.
module snake_move_control
  import snake_move_control_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = BASE_PERIOD_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int unsigned QDEPTH      = QDEPTH_DEF
) (
  input logic                 Clk,
  input logic                 Reset,
  snake_move_control_if.slave bus
);
  localparam int unsigned CW = $clog2(BASE_PERIOD + 1);

  logic          run_q, run_d;
  dir_e          dirn_q, dirn_d;
  logic          turn_avail_q, turn_avail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;

  logic          run_entry;
  logic          tick;
  logic          pop;
  logic          push;
  logic          cand_vld;
  dir_e          cand;
  dir_e          ref_dir;
  logic [1:0]    fifo_head;
  logic [1:0]    fifo_last;
  logic          fifo_full;
  logic          fifo_empty;

  snake_dir_fifo #(
    .DEPTH (QDEPTH),
    .W     (2)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .flush (~bus.q_Run),
    .push  (push),
    .din   (cand),
    .pop   (pop),
    .head  (fifo_head),
    .last  (fifo_last),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign run_entry = bus.q_Run & ~run_q;
  // The entry cycle does not count, so the first tick lands a full period after entry.
  assign tick      = bus.q_Run & run_q & (cnt_q == period_q - CW'(1));
  assign pop       = bus.q_Run & turn_avail_q & ~fifo_empty & ~tick;

  // Filter against the newest queued turn, since that is where the snake will be heading.
  always_comb begin
    cand     = DIR_UP;
    cand_vld = bus.q_Run & (bus.BtnU | bus.BtnD | bus.BtnL | bus.BtnR);
    if (bus.BtnU) begin
      cand = DIR_UP;
    end else if (bus.BtnD) begin
      cand = DIR_DOWN;
    end else if (bus.BtnL) begin
      cand = DIR_LEFT;
    end else begin
      cand = DIR_RIGHT;
    end
    ref_dir = fifo_empty ? dirn_q : dir_e'(fifo_last);
    push    = cand_vld && !is_reversal(cand, ref_dir) && (cand != ref_dir) && !fifo_full;
  end

  always_comb begin
    run_d        = bus.q_Run;
    dirn_d       = pop ? dir_e'(fifo_head) : dirn_q;
    turn_avail_d = turn_avail_q;
    if (pop) begin
      turn_avail_d = 1'b0;
    end
    if (tick || run_entry) begin
      turn_avail_d = 1'b1;
    end

    if (!bus.q_Run || run_entry || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // Length is sampled only at period boundaries so a move in flight keeps its duration.
    period_d = period_q;
    if (run_entry || tick) begin
      period_d = CW'(move_period(bus.Length, BASE_PERIOD, STEP, MIN_PERIOD));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run_q        <= 1'b0;
      dirn_q       <= DIR_UP;
      turn_avail_q <= 1'b1;
      cnt_q        <= '0;
      period_q     <= CW'(BASE_PERIOD);
    end else begin
      run_q        <= run_d;
      dirn_q       <= dirn_d;
      turn_avail_q <= turn_avail_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
    end
  end

  assign bus.In_Dirn   = dirn_q;
  assign bus.SCEN      = pop;
  assign bus.Speed_Clk = tick;

endmodule

// File: tb/tb_snake_move_control.sv
// Directed bench for snake_move_control with a 20-cycle base period.
// Inputs change 1 time unit after posedge; outputs are sampled on the falling edge.
module tb_snake_move_control;
  import snake_move_control_pkg::*;

  localparam logic [3:0] B_U = 4'b1000;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_R = 4'b0001;

  logic Clk;
  logic Reset;
  logic run;
  logic [7:0] len;
  int cur;
  int checks;
  int errors;
  int tick_cnt;
  int scen_cnt;
  int clash_cnt;
  int first_tick;
  int tks[$];
  int exp_tk[5];

  snake_move_control_if bus ();

  snake_move_control #(
    .BASE_PERIOD (20),
    .STEP        (2),
    .MIN_PERIOD  (6),
    .QDEPTH      (2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] b);
    @(posedge Clk);
    #1;
    bus.q_Run  = run;
    bus.Length = len;
    bus.BtnU   = b[3];
    bus.BtnD   = b[2];
    bus.BtnL   = b[1];
    bus.BtnR   = b[0];
    cur++;
    @(negedge Clk);
    if (bus.Speed_Clk) tick_cnt++;
    if (bus.SCEN) scen_cnt++;
    if (bus.SCEN && bus.Speed_Clk) clash_cnt++;
  endtask

  task automatic go_to(input int n);
    while (cur < n) cyc(4'b0000);
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    run        = 1'b0;
    len        = 8'd3;
    bus.q_Run  = 1'b0;
    bus.Length = 8'd3;
    bus.BtnU   = 1'b0;
    bus.BtnD   = 1'b0;
    bus.BtnL   = 1'b0;
    bus.BtnR   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Index 0 is the Run entry cycle.
  task automatic start_run();
    run      = 1'b1;
    cur      = -1;
    tick_cnt = 0;
    scen_cnt = 0;
    cyc(4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    clash_cnt = 0;
    cur       = 0;

    do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("rst_dirn", int'(bus.In_Dirn), 0);
    check_eq("rst_scen", int'(bus.SCEN), 0);
    check_eq("rst_tick", int'(bus.Speed_Clk), 0);
    do_reset();

    // Idle run: ticks every 20 cycles starting 20 after entry.
    start_run();
    check_eq("entry_no_tick", int'(bus.Speed_Clk), 0);
    first_tick = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(4'b0000);
      if (bus.Speed_Clk && first_tick < 0) first_tick = cur;
    end
    check_eq("first_tick_idx", first_tick, 20);
    check_eq("tick_count_60", tick_cnt, 3);
    check_eq("idle_no_scen", scen_cnt, 0);
    check_eq("idle_dirn", int'(bus.In_Dirn), 0);

    // D+L together: D wins and is a reversal, so nothing is queued.
    cyc(B_D | B_L);
    cyc(4'b0000);
    check_eq("rev_drop", int'(bus.SCEN), 0);
    cyc(B_L | B_R);
    check_eq("push_not_same_cycle", int'(bus.SCEN), 0);
    cyc(4'b0000);
    check_eq("scen_left", int'(bus.SCEN), 1);
    cyc(4'b0000);
    check_eq("dirn_left", int'(bus.In_Dirn), 2);
    check_eq("scen_one_cycle", int'(bus.SCEN), 0);

    // Two turns after a tick: first commits at once, second waits for the next tick.
    do_reset();
    start_run();
    go_to(20);
    check_eq("s3_tick20", int'(bus.Speed_Clk), 1);
    cyc(B_L);
    cyc(4'b0000);
    check_eq("s3_scen_l", int'(bus.SCEN), 1);
    cyc(B_D);
    check_eq("s3_dirn_l", int'(bus.In_Dirn), 2);
    scen_cnt = 0;
    go_to(29);
    cyc(B_D);
    go_to(40);
    check_eq("s3_held", scen_cnt, 0);
    check_eq("s3_tick40", int'(bus.Speed_Clk), 1);
    check_eq("s3_no_scen_on_tick", int'(bus.SCEN), 0);
    cyc(4'b0000);
    check_eq("s3_scen_d", int'(bus.SCEN), 1);
    cyc(4'b0000);
    check_eq("s3_dirn_d", int'(bus.In_Dirn), 1);
    scen_cnt = 0;
    go_to(65);
    check_eq("s3_dup_drop", scen_cnt, 0);

    // Full queue drops a third turn.
    do_reset();
    start_run();
    cyc(B_R);
    cyc(4'b0000);
    cyc(B_U);
    go_to(22);
    check_eq("s4_dirn_up", int'(bus.In_Dirn), 0);
    cyc(B_L);
    cyc(B_D);
    cyc(B_R);
    go_to(42);
    check_eq("s4_pop_l", int'(bus.In_Dirn), 2);
    go_to(62);
    check_eq("s4_pop_d", int'(bus.In_Dirn), 1);
    scen_cnt = 0;
    go_to(85);
    check_eq("s4_r_dropped", scen_cnt, 0);
    check_eq("s4_dirn_final", int'(bus.In_Dirn), 1);

    // Period follows Length only at tick boundaries.
    do_reset();
    start_run();
    tks.delete();
    for (int i = 1; i <= 70; i++) begin
      if (i == 5) len = 8'd5;
      if (i == 25) len = 8'd200;
      if (i == 45) len = 8'd0;
      cyc(4'b0000);
      if (bus.Speed_Clk) tks.push_back(cur);
    end
    exp_tk = '{20, 36, 42, 48, 68};
    check_eq("len_tick_count", tks.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("len_tick%0d", i), (i < tks.size()) ? tks[i] : -1, exp_tk[i]);
    end

    // Leaving Run flushes the queue and discards the partial count.
    do_reset();
    start_run();
    cyc(B_R);
    cyc(4'b0000);
    cyc(B_U);
    cyc(B_L);
    go_to(9);
    run      = 1'b0;
    tick_cnt = 0;
    scen_cnt = 0;
    go_to(11);
    cyc(B_L);
    go_to(25);
    check_eq("off_no_tick", tick_cnt, 0);
    check_eq("off_no_scen", scen_cnt, 0);
    check_eq("off_dirn_hold", int'(bus.In_Dirn), 3);
    run      = 1'b1;
    tick_cnt = 0;
    scen_cnt = 0;
    go_to(45);
    check_eq("reentry_flushed", scen_cnt, 0);
    check_eq("reentry_early_tick", tick_cnt, 0);
    cyc(4'b0000);
    check_eq("reentry_tick46", int'(bus.Speed_Clk), 1);

    // Async reset while ticking with turns queued.
    do_reset();
    start_run();
    cyc(B_R);
    cyc(4'b0000);
    cyc(B_U);
    cyc(B_L);
    go_to(20);
    check_eq("ar_pre_tick", int'(bus.Speed_Clk), 1);
    check_eq("ar_pre_dirn", int'(bus.In_Dirn), 3);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("ar_dirn", int'(bus.In_Dirn), 0);
    check_eq("ar_tick", int'(bus.Speed_Clk), 0);
    check_eq("ar_scen", int'(bus.SCEN), 0);
    run       = 1'b0;
    bus.q_Run = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    start_run();
    go_to(19);
    check_eq("ar_after_no_scen", scen_cnt, 0);
    check_eq("ar_after_no_tick", tick_cnt, 0);
    cyc(4'b0000);
    check_eq("ar_after_tick20", int'(bus.Speed_Clk), 1);

    check_eq("scen_tick_clash", clash_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
